// File: rtl/index_buff_pp_sched_pkg.sv
// -----------------------------------------------------------------------------
// index_buff_pp_sched_pkg
// Shared definitions for the index-buffer ping-pong scheduler:
//   - bank encoding (BANK_LOW / BANK_HIGH)
//   - write FSM state encoding
//   - Addr_end width derived from the buffer read address width
// -----------------------------------------------------------------------------
package index_buff_pp_sched_pkg;

    localparam logic BANK_LOW  = 1'b0;
    localparam logic BANK_HIGH = 1'b1;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t W_IDLE  = 2'd0;
    localparam wr_state_t W_ISSUE = 2'd1;
    localparam wr_state_t W_FILL  = 2'd2;
    localparam wr_state_t W_WAIT  = 2'd3;

    // Addr_end carries 5 bits beyond the read address (word-within-line select).
    localparam int ADDR_END_EXTRA = 5;

    function automatic int addr_end_w(input int read_addr_width);
        return read_addr_width + ADDR_END_EXTRA;
    endfunction

    function automatic logic other_bank(input logic bank);
        return (bank == BANK_LOW) ? BANK_HIGH : BANK_LOW;
    endfunction

endpackage

// File: rtl/index_buff_pp_sched_bank_status.sv
// -----------------------------------------------------------------------------
// index_buff_pp_sched_bank_status
// Read-side bookkeeping: per-bank full flags, read bank pointer, drain counter.
// Ports:
//   clki, rst        clock, synchronous active-high reset
//   fill_set         a tile finished loading into fill_bank
//   fill_bank        bank that fill_set refers to
//   rd_done          consumer released the current read bank
//   tile_num         tiles in the current layer
//   full             full flags, one per bank
//   rd_bank          bank presented to the reader
//   rd_valid         rd_bank holds a complete tile
//   drain_last       final tile of the layer is being released this cycle
// -----------------------------------------------------------------------------
module index_buff_pp_sched_bank_status
    import index_buff_pp_sched_pkg::*;
#(
    parameter int Tile_Cnt_Width = 16
) (
    input  logic                      clki,
    input  logic                      rst,
    input  logic                      fill_set,
    input  logic                      fill_bank,
    input  logic                      rd_done,
    input  logic [Tile_Cnt_Width-1:0] tile_num,
    output logic [1:0]                full,
    output logic                      rd_bank,
    output logic                      rd_valid,
    output logic                      drain_last
);

    localparam logic [Tile_Cnt_Width-1:0] CNT_ONE = 1;

    logic [1:0]                full_q, full_d;
    logic                      rd_bank_q, rd_bank_d;
    logic [Tile_Cnt_Width-1:0] drain_cnt_q, drain_cnt_d;
    logic                      rd_acc;

    assign rd_acc     = rd_done && full_q[rd_bank_q];
    assign drain_last = rd_acc && ((drain_cnt_q + CNT_ONE) == tile_num);

    always_comb begin
        full_d      = full_q;
        rd_bank_d   = rd_bank_q;
        drain_cnt_d = drain_cnt_q;
        // fill and release always target different banks, so both apply
        if (fill_set)
            full_d[fill_bank] = 1'b1;
        if (rd_acc) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = other_bank(rd_bank_q);
            drain_cnt_d       = drain_cnt_q + CNT_ONE;
        end
        // layer complete: return to the idle state for the next layer
        if (drain_last) begin
            full_d      = '0;
            rd_bank_d   = BANK_LOW;
            drain_cnt_d = '0;
        end
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            full_q      <= '0;
            rd_bank_q   <= BANK_LOW;
            drain_cnt_q <= '0;
        end else begin
            full_q      <= full_d;
            rd_bank_q   <= rd_bank_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign full     = full_q;
    assign rd_bank  = rd_bank_q;
    assign rd_valid = full_q[rd_bank_q];

endmodule

// File: rtl/index_buff_pp_sched.sv
// -----------------------------------------------------------------------------
// index_buff_pp_sched
// Ping-pong scheduler for the index buffer. Loads tiles alternately into the
// low/high banks via the buffer controller while the sparse-PE side drains the
// other bank, across one layer of tile_num tiles.
// Ports:
//   clki, rst                  clock, synchronous active-high reset
//   start, tile_num,
//   addr_end_cfg               layer start pulse and its configuration
//   fill_start / fill_finished buffer controller handshake
//   Addr_end                   latched per-tile end address
//   ping_pong_write            bank being written
//   ping_pong_read, rd_valid,
//   rd_done                    read side: bank, full indication, release pulse
//   busy, layer_done           layer status
// -----------------------------------------------------------------------------
module index_buff_pp_sched
    import index_buff_pp_sched_pkg::*;
#(
    parameter int Read_Addr_Width = 11,
    parameter int Tile_Cnt_Width  = 16,
    localparam int AE_W           = addr_end_w(Read_Addr_Width)
) (
    input  logic                      clki,
    input  logic                      rst,
    input  logic                      start,
    input  logic [Tile_Cnt_Width-1:0] tile_num,
    input  logic [AE_W-1:0]           addr_end_cfg,
    output logic                      fill_start,
    input  logic                      fill_finished,
    output logic [AE_W-1:0]           Addr_end,
    output logic                      ping_pong_write,
    output logic                      ping_pong_read,
    output logic                      rd_valid,
    input  logic                      rd_done,
    output logic                      busy,
    output logic                      layer_done
);

    localparam logic [Tile_Cnt_Width-1:0] CNT_ONE = 1;

    wr_state_t                 wr_state_q, wr_state_d;
    logic                      busy_q, busy_d;
    logic                      wr_bank_q, wr_bank_d;
    logic                      layer_done_q, layer_done_d;
    logic [Tile_Cnt_Width-1:0] fill_cnt_q, fill_cnt_d;
    logic [Tile_Cnt_Width-1:0] tile_num_q, tile_num_d;
    logic [AE_W-1:0]           addr_end_q, addr_end_d;

    logic [1:0] full;
    logic       rd_bank;
    logic       drain_last;
    logic       start_acc;
    logic       fill_set;

    assign start_acc = start && !busy_q;
    // fill_finished only counts while a fill is outstanding
    assign fill_set  = (wr_state_q == W_FILL) && fill_finished;

    index_buff_pp_sched_bank_status #(
        .Tile_Cnt_Width (Tile_Cnt_Width)
    ) u_bank_status (
        .clki       (clki),
        .rst        (rst),
        .fill_set   (fill_set),
        .fill_bank  (wr_bank_q),
        .rd_done    (rd_done),
        .tile_num   (tile_num_q),
        .full       (full),
        .rd_bank    (rd_bank),
        .rd_valid   (rd_valid),
        .drain_last (drain_last)
    );

    always_comb begin
        wr_state_d   = wr_state_q;
        busy_d       = busy_q;
        wr_bank_d    = wr_bank_q;
        fill_cnt_d   = fill_cnt_q;
        tile_num_d   = tile_num_q;
        addr_end_d   = addr_end_q;
        layer_done_d = 1'b0;

        if (start_acc) begin
            tile_num_d = tile_num;
            addr_end_d = addr_end_cfg;
            // empty layer completes immediately without touching the buffer
            if (tile_num == '0) begin
                layer_done_d = 1'b1;
            end else begin
                busy_d     = 1'b1;
                wr_state_d = W_ISSUE;
            end
        end

        case (wr_state_q)
            W_ISSUE: wr_state_d = full[wr_bank_q] ? W_WAIT : W_FILL;
            W_FILL: begin
                if (fill_finished) begin
                    wr_bank_d  = other_bank(wr_bank_q);
                    fill_cnt_d = fill_cnt_q + CNT_ONE;
                    // after the last load, idle with busy held until drained
                    wr_state_d = ((fill_cnt_q + CNT_ONE) == tile_num_q) ? W_IDLE : W_ISSUE;
                end
            end
            W_WAIT: if (!full[wr_bank_q]) wr_state_d = W_ISSUE;
            default: ;
        endcase

        if (drain_last) begin
            layer_done_d = 1'b1;
            busy_d       = 1'b0;
            wr_state_d   = W_IDLE;
            wr_bank_d    = BANK_LOW;
            fill_cnt_d   = '0;
        end
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            wr_state_q   <= W_IDLE;
            busy_q       <= 1'b0;
            wr_bank_q    <= BANK_LOW;
            layer_done_q <= 1'b0;
            fill_cnt_q   <= '0;
            tile_num_q   <= '0;
            addr_end_q   <= '0;
        end else begin
            wr_state_q   <= wr_state_d;
            busy_q       <= busy_d;
            wr_bank_q    <= wr_bank_d;
            layer_done_q <= layer_done_d;
            fill_cnt_q   <= fill_cnt_d;
            tile_num_q   <= tile_num_d;
            addr_end_q   <= addr_end_d;
        end
    end

    // one-cycle pulse: W_ISSUE always leaves after a single cycle
    assign fill_start      = (wr_state_q == W_ISSUE) && !full[wr_bank_q];
    assign Addr_end        = addr_end_q;
    assign ping_pong_write = wr_bank_q;
    assign ping_pong_read  = rd_bank;
    assign busy            = busy_q;
    assign layer_done      = layer_done_q;

endmodule

// File: tb/tb_index_buff_pp_sched.sv
module tb_index_buff_pp_sched;

    localparam int RAW = 11;
    localparam int TW  = 16;
    localparam int AEW = RAW + 5;

    localparam int K_FS = 0;  // fill_start pulse
    localparam int K_LD = 1;  // layer_done pulse
    localparam int K_RV = 2;  // rd_valid rising edge

    logic           clki = 1'b0;
    logic           rst, start, fill_finished, rd_done;
    logic [TW-1:0]  tile_num;
    logic [AEW-1:0] addr_end_cfg;
    logic           fill_start, ping_pong_write, ping_pong_read, rd_valid, busy, layer_done;
    logic [AEW-1:0] Addr_end;

    index_buff_pp_sched #(.Read_Addr_Width(RAW), .Tile_Cnt_Width(TW)) dut (
        .clki(clki), .rst(rst), .start(start), .tile_num(tile_num),
        .addr_end_cfg(addr_end_cfg), .fill_start(fill_start),
        .fill_finished(fill_finished), .Addr_end(Addr_end),
        .ping_pong_write(ping_pong_write), .ping_pong_read(ping_pong_read),
        .rd_valid(rd_valid), .rd_done(rd_done), .busy(busy), .layer_done(layer_done)
    );

    always #5 clki = ~clki;

    int cyc = 0;
    always @(posedge clki) cyc <= cyc + 1;

    typedef struct {
        int             kind;
        int             cyc;
        logic           ppw;
        logic           ppr;
        logic [AEW-1:0] ae;
        logic           busy;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic expect_ev(input int kind, input int c, input logic ppw, input logic ppr,
                             input logic [AEW-1:0] ae, input logic bsy);
        ev_t e;
        e.kind = kind; e.cyc = c; e.ppw = ppw; e.ppr = ppr; e.ae = ae; e.busy = bsy;
        exp_q.push_back(e);
    endtask

    task automatic cmp_ev(input int kind);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d at cyc=%0d, required no event", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.cyc == cyc && e.ppw == ping_pong_write &&
                e.ppr == ping_pong_read && e.ae == Addr_end && e.busy == busy)
                n_pass++;
            else
                $display("FAIL event: got kind=%0d cyc=%0d ppw=%0b ppr=%0b ae=%h busy=%0b, required kind=%0d cyc=%0d ppw=%0b ppr=%0b ae=%h busy=%0b",
                         kind, cyc, ping_pong_write, ping_pong_read, Addr_end, busy,
                         e.kind, e.cyc, e.ppw, e.ppr, e.ae, e.busy);
        end
    endtask

    // monitor: every output event is matched against the scoreboard
    logic rv_prev = 1'b0;
    always @(negedge clki) begin
        if (fill_start)            cmp_ev(K_FS);
        if (layer_done)            cmp_ev(K_LD);
        if (rd_valid && !rv_prev)  cmp_ev(K_RV);
        rv_prev = rd_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp_v);
    endtask

    task automatic step();
        @(posedge clki);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    int t;

    initial begin
        rst = 1'b1; start = 1'b0; fill_finished = 1'b0; rd_done = 1'b0;
        tile_num = '0; addr_end_cfg = '0;
        step(); step(); step();
        rst = 1'b0;

        // reset state
        chk("rst_fill_start", 32'(fill_start), 0);
        chk("rst_addr_end",   32'(Addr_end), 0);
        chk("rst_ppw",        32'(ping_pong_write), 0);
        chk("rst_ppr",        32'(ping_pong_read), 0);
        chk("rst_rd_valid",   32'(rd_valid), 0);
        chk("rst_busy",       32'(busy), 0);
        chk("rst_layer_done", 32'(layer_done), 0);

        // empty layer
        step(); t = cyc;
        start = 1'b1; tile_num = 16'd0; addr_end_cfg = 16'h0123;
        expect_ev(K_LD, t + 1, 1'b0, 1'b0, 16'h0123, 1'b0);
        step(); start = 1'b0;
        step();
        chk("empty_busy", 32'(busy), 0);

        // single tile
        goto(t + 5); t = cyc;
        start = 1'b1; tile_num = 16'd1; addr_end_cfg = 16'h01FF;
        expect_ev(K_FS, t + 1, 1'b0, 1'b0, 16'h01FF, 1'b1);
        step(); start = 1'b0;
        goto(t + 10);
        chk("one_addr_end", 32'(Addr_end), 32'h01FF);
        goto(t + 21); fill_finished = 1'b1;
        expect_ev(K_RV, t + 22, 1'b1, 1'b0, 16'h01FF, 1'b1);
        step(); fill_finished = 1'b0;
        goto(t + 25); rd_done = 1'b1;
        expect_ev(K_LD, t + 26, 1'b0, 1'b0, 16'h01FF, 1'b0);
        step(); rd_done = 1'b0;

        // four tiles, consumer stalls, plus spurious inputs
        goto(t + 30); t = cyc;
        start = 1'b1; tile_num = 16'd4; addr_end_cfg = 16'h02A5;
        expect_ev(K_FS, t + 1, 1'b0, 1'b0, 16'h02A5, 1'b1);
        step(); start = 1'b0;
        goto(t + 3); rd_done = 1'b1;             // no full bank yet: ignored
        step(); rd_done = 1'b0;
        goto(t + 5); fill_finished = 1'b1;
        expect_ev(K_FS, t + 6, 1'b1, 1'b0, 16'h02A5, 1'b1);
        expect_ev(K_RV, t + 6, 1'b1, 1'b0, 16'h02A5, 1'b1);
        step(); fill_finished = 1'b0;
        goto(t + 10); fill_finished = 1'b1;      // both banks now full
        step(); fill_finished = 1'b0;
        goto(t + 15); fill_finished = 1'b1;      // in W_WAIT: ignored
        step(); fill_finished = 1'b0;
        start = 1'b1; tile_num = 16'd0; addr_end_cfg = 16'h07FF;  // busy: ignored
        step(); start = 1'b0;
        goto(t + 18);
        chk("stall_ppw",      32'(ping_pong_write), 0);
        chk("stall_ppr",      32'(ping_pong_read), 0);
        chk("stall_rd_valid", 32'(rd_valid), 1);
        chk("stall_addr_end", 32'(Addr_end), 32'h02A5);
        goto(t + 20); rd_done = 1'b1;
        expect_ev(K_FS, t + 22, 1'b0, 1'b1, 16'h02A5, 1'b1);
        step(); rd_done = 1'b0;
        goto(t + 26); fill_finished = 1'b1;
        step(); fill_finished = 1'b0;
        goto(t + 30); rd_done = 1'b1;
        expect_ev(K_FS, t + 32, 1'b1, 1'b0, 16'h02A5, 1'b1);
        step(); rd_done = 1'b0;
        goto(t + 36); fill_finished = 1'b1;
        step(); fill_finished = 1'b0;
        goto(t + 40); rd_done = 1'b1;
        step(); rd_done = 1'b0;
        goto(t + 42); rd_done = 1'b1;
        expect_ev(K_LD, t + 43, 1'b0, 1'b0, 16'h02A5, 1'b0);
        step(); rd_done = 1'b0;

        // three tiles with simultaneous fill_finished and rd_done
        goto(t + 46); t = cyc;
        start = 1'b1; tile_num = 16'd3; addr_end_cfg = 16'h0310;
        expect_ev(K_FS, t + 1, 1'b0, 1'b0, 16'h0310, 1'b1);
        step(); start = 1'b0;
        goto(t + 4); fill_finished = 1'b1;
        expect_ev(K_FS, t + 5, 1'b1, 1'b0, 16'h0310, 1'b1);
        expect_ev(K_RV, t + 5, 1'b1, 1'b0, 16'h0310, 1'b1);
        step(); fill_finished = 1'b0;
        goto(t + 8); fill_finished = 1'b1; rd_done = 1'b1;
        expect_ev(K_FS, t + 9, 1'b0, 1'b1, 16'h0310, 1'b1);
        step(); fill_finished = 1'b0; rd_done = 1'b0;
        goto(t + 10);
        chk("sim_ppr",      32'(ping_pong_read), 1);
        chk("sim_ppw",      32'(ping_pong_write), 0);
        chk("sim_rd_valid", 32'(rd_valid), 1);
        goto(t + 12); fill_finished = 1'b1;
        step(); fill_finished = 1'b0;
        goto(t + 14); rd_done = 1'b1;
        step(); rd_done = 1'b0;
        goto(t + 16); rd_done = 1'b1;
        expect_ev(K_LD, t + 17, 1'b0, 1'b0, 16'h0310, 1'b0);
        step(); rd_done = 1'b0;

        // reset during W_FILL, then a fresh layer
        goto(t + 20); t = cyc;
        start = 1'b1; tile_num = 16'd2; addr_end_cfg = 16'h00C3;
        expect_ev(K_FS, t + 1, 1'b0, 1'b0, 16'h00C3, 1'b1);
        step(); start = 1'b0;
        goto(t + 4); rst = 1'b1; fill_finished = 1'b1;
        step(); rst = 1'b0; fill_finished = 1'b0;
        chk("mid_rst_busy",       32'(busy), 0);
        chk("mid_rst_addr_end",   32'(Addr_end), 0);
        chk("mid_rst_rd_valid",   32'(rd_valid), 0);
        chk("mid_rst_ppw",        32'(ping_pong_write), 0);
        chk("mid_rst_fill_start", 32'(fill_start), 0);
        goto(t + 8); t = cyc;
        start = 1'b1; tile_num = 16'd1; addr_end_cfg = 16'h00AA;
        expect_ev(K_FS, t + 1, 1'b0, 1'b0, 16'h00AA, 1'b1);
        step(); start = 1'b0;
        goto(t + 3); fill_finished = 1'b1;
        expect_ev(K_RV, t + 4, 1'b1, 1'b0, 16'h00AA, 1'b1);
        step(); fill_finished = 1'b0;
        goto(t + 6); rd_done = 1'b1;
        expect_ev(K_LD, t + 7, 1'b0, 1'b0, 16'h00AA, 1'b0);
        step(); rd_done = 1'b0;

        goto(t + 12);
        chk("pending_events", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
